// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets several word sources share one UART
// transmitter. A grant is held for a whole packet. It is released on the
// word flagged last, on reaching a maximum word count, or when the granted
// source stalls for too long.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    per-requester word available
//   req_data     requester i word in bits [i*WORD_WIDTH +: WORD_WIDTH]
//   req_last     per-requester "current word ends packet"
//   req_ready    per-requester "word consumed this cycle" (combinational)
//   tx_dout      word presented to the transmitter (combinational)
//   tx_empty     no word for the transmitter (combinational)
//   tx_re        transmitter reads tx_dout
//   busy         a grant is held
//   grant_id     current grant while locked, last grant while idle
//   err_timeout  one-cycle pulse after a stall-timeout release
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned WORD_WIDTH       = 8,
    parameter int unsigned MAX_PACKET_WORDS = 256,
    parameter int unsigned IDLE_TIMEOUT     = 1024,
    localparam int unsigned ID_WIDTH        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [WORD_WIDTH-1:0]         tx_dout,
    output logic                          tx_empty,
    input  logic                          tx_re,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          err_timeout
);

    localparam int unsigned WCNT_W  = $clog2(MAX_PACKET_WORDS + 1);
    localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [ID_WIDTH-1:0]  grant, grant_n;
    logic [ID_WIDTH-1:0]  last_grant, last_grant_n;
    logic [WCNT_W-1:0]    word_cnt, word_cnt_n;
    logic [STALL_W-1:0]   stall_cnt, stall_cnt_n;
    logic                 err_n;

    logic                 found;
    logic [ID_WIDTH-1:0]  pick;
    logic                 grant_valid;
    logic                 grant_last;
    logic                 xfer;
    logic [WCNT_W-1:0]    word_inc;
    logic [STALL_W-1:0]   stall_inc;

    // Round-robin pick: first valid requester after last_grant, with wrap.
    always_comb begin
        int unsigned cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_grant) + off) % NUM_REQ;
            if (!found && req_valid[ID_WIDTH'(cand)]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(cand);
            end
        end
    end

    // Granted requester's valid/last/data, selected with a constant-index mux.
    always_comb begin
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        tx_dout     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_WIDTH'(i) == grant) begin
                grant_valid = req_valid[i];
                grant_last  = req_last[i];
                if (state == LOCKED) begin
                    tx_dout = req_data[i*int'(WORD_WIDTH) +: WORD_WIDTH];
                end
            end
        end
    end

    // A read against an empty output is ignored; reset suppresses consumption
    // in the cycle it is asserted so an abandoned packet loses no word.
    assign xfer      = (state == LOCKED) && tx_re && grant_valid && !rst;
    assign word_inc  = word_cnt + WCNT_W'(1);
    assign stall_inc = stall_cnt + STALL_W'(1);

    // Handshake and status outputs.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant] = 1'b1;
        end
        tx_empty = (state == LOCKED) ? !grant_valid : 1'b1;
        busy     = (state == LOCKED);
        grant_id = (state == LOCKED) ? grant : last_grant;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= ID_WIDTH'(NUM_REQ - 1);
            last_grant  <= ID_WIDTH'(NUM_REQ - 1);
            word_cnt    <= '0;
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last_grant  <= last_grant_n;
            word_cnt    <= word_cnt_n;
            stall_cnt   <= stall_cnt_n;
            err_timeout <= err_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        word_cnt_n   = word_cnt;
        stall_cnt_n  = stall_cnt;
        err_n        = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n     = LOCKED;
                    grant_n     = pick;
                    word_cnt_n  = '0;
                    stall_cnt_n = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    // A transfer always clears the stall count, so it wins
                    // over a timeout that would otherwise land this cycle.
                    word_cnt_n  = word_inc;
                    stall_cnt_n = '0;
                    if (grant_last || (word_inc == WCNT_W'(MAX_PACKET_WORDS))) begin
                        state_n      = IDLE;
                        last_grant_n = grant;
                    end
                end else if (!grant_valid) begin
                    stall_cnt_n = stall_inc;
                    if (stall_inc == STALL_W'(IDLE_TIMEOUT)) begin
                        state_n      = IDLE;
                        last_grant_n = grant;
                        stall_cnt_n  = '0;
                        err_n        = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
